// File: rtl/reflet_bus_arbiter.sv
// ============================================================================
// Module      : reflet_bus_arbiter
// Description : Two-master round-robin arbiter for the reflet system bus.
//               Bounded hold time, optional lock, and one dead cycle between
//               owners.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reflet_bus_arbiter #(
    parameter int wordsize = 8,
    parameter int max_hold = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                lock0,
    input  logic [wordsize-1:0] addr0,
    input  logic [wordsize-1:0] wdata0,
    input  logic                we0,
    output logic                grant0,
    output logic                rvalid0,
    input  logic                req1,
    input  logic                lock1,
    input  logic [wordsize-1:0] addr1,
    input  logic [wordsize-1:0] wdata1,
    input  logic                we1,
    output logic                grant1,
    output logic                rvalid1,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_wdata,
    output logic                bus_we,
    output logic                bus_enable
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(max_hold - 1);
    localparam logic [7:0] HOLD_SAT   = 8'hFF;

    state_t      state;
    state_t      state_next;
    logic        last;
    logic        last_next;
    logic        pend;
    logic        pend_next;
    logic [7:0]  hold_cnt;
    logic [7:0]  hold_next;
    logic        hold_expired;
    state_t      arb_pick;
    logic        pend_req;

    // Fresh arbitration from an idle bus; ties go to whoever did not own last.
    always_comb begin
        arb_pick = IDLE;
        if (req0 && req1) begin
            arb_pick = last ? OWN0 : OWN1;
        end else if (req0) begin
            arb_pick = OWN0;
        end else if (req1) begin
            arb_pick = OWN1;
        end
    end

    assign hold_expired = (hold_cnt >= HOLD_LIMIT);
    assign pend_req     = pend ? req1 : req0;

    always_comb begin
        state_next = state;
        pend_next  = pend;
        case (state)
            IDLE: begin
                state_next = arb_pick;
            end
            OWN0: begin
                if (!req0) begin
                    if (req1) begin
                        state_next = TURN;
                        pend_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (req1 && !lock0 && hold_expired) begin
                    state_next = TURN;
                    pend_next  = 1'b1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    if (req0) begin
                        state_next = TURN;
                        pend_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (req0 && !lock1 && hold_expired) begin
                    state_next = TURN;
                    pend_next  = 1'b0;
                end
            end
            TURN: begin
                if (pend_req) begin
                    state_next = pend ? OWN1 : OWN0;
                end else begin
                    state_next = arb_pick;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        last_next = last;
        if (state_next == OWN0) begin
            last_next = 1'b0;
        end else if (state_next == OWN1) begin
            last_next = 1'b1;
        end
    end

    // The counter restarts on every new ownership and sticks at its ceiling.
    always_comb begin
        hold_next = 8'd0;
        if ((state_next == state) && ((state == OWN0) || (state == OWN1))) begin
            hold_next = (hold_cnt == HOLD_SAT) ? HOLD_SAT : hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            pend     <= 1'b0;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            last     <= last_next;
            pend     <= pend_next;
            hold_cnt <= hold_next;
        end
    end

    assign grant0 = (state == OWN0);
    assign grant1 = (state == OWN1);

    // Non-owning states must drive zeros: the read bus downstream is OR-ed.
    always_comb begin
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_we     = 1'b0;
        bus_enable = 1'b0;
        case (state)
            OWN0: begin
                bus_addr   = addr0;
                bus_wdata  = wdata0;
                bus_we     = we0;
                bus_enable = 1'b1;
            end
            OWN1: begin
                bus_addr   = addr1;
                bus_wdata  = wdata1;
                bus_we     = we1;
                bus_enable = 1'b1;
            end
            default: begin
                bus_addr   = '0;
                bus_wdata  = '0;
                bus_we     = 1'b0;
                bus_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= grant0 & ~we0;
            rvalid1 <= grant1 & ~we1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reflet_bus_arbiter.sv
// ============================================================================
// Module      : tb_reflet_bus_arbiter
// Description : Scoreboard bench for reflet_bus_arbiter (max_hold = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reflet_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, lock0 = 1'b0, we0 = 1'b0;
    logic       req1 = 1'b0, lock1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = 8'h00, wdata0 = 8'h00;
    logic [7:0] addr1 = 8'h00, wdata1 = 8'h00;
    logic       grant0, grant1, rvalid0, rvalid1;
    logic [7:0] bus_addr, bus_wdata;
    logic       bus_we, bus_enable;

    int n_checks = 0;
    int n_fail   = 0;

    logic [21:0] sb[$];
    logic [21:0] exp_v;
    logic [21:0] got_v;

    reflet_bus_arbiter #(.wordsize(8), .max_hold(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
        .grant0(grant0), .rvalid0(rvalid0),
        .req1(req1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .grant1(grant1), .rvalid1(rvalid1),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_enable(bus_enable)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] pk(input logic g0, input logic g1,
                                       input logic rv0, input logic rv1,
                                       input logic en, input logic we,
                                       input logic [7:0] a, input logic [7:0] d);
        return {g0, g1, rv0, rv1, en, we, a, d};
    endfunction

    function automatic logic [21:0] observe();
        return {grant0, grant1, rvalid0, rvalid1, bus_enable, bus_we, bus_addr, bus_wdata};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if ((grant0 & grant1) !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_grant_overlap: grant0=%b grant1=%b required not both 1", grant0, grant1);
            end
            n_checks++;
            if ((rvalid0 & rvalid1) !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_rvalid_overlap: rvalid0=%b rvalid1=%b required not both 1", rvalid0, rvalid1);
            end
            n_checks++;
            if (bus_we && !(grant0 ^ grant1)) begin
                n_fail++;
                $display("FAIL inv_we_owner: bus_we=1 with grants %b%b required exactly one", grant0, grant1);
            end
            n_checks++;
            if (!grant0 && !grant1 && ({bus_enable, bus_we, bus_addr, bus_wdata} !== 18'd0)) begin
                n_fail++;
                $display("FAIL inv_bus_quiet: bus=%h required 0 with no owner",
                         {bus_enable, bus_we, bus_addr, bus_wdata});
            end
        end
    end

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        got_v = observe();
        if (got_v !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h required %h", got_v, 22'd0);
        end
        step();
        step();
        n_checks++;
        got_v = observe();
        if (got_v !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_held: got %h required %h", got_v, 22'd0);
        end
        reset = 1'b1;
        step();
        n_checks++;
        got_v = observe();
        if (got_v !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h required %h", got_v, 22'd0);
        end
    endtask

    task automatic test_single();
        req0 = 1'b1; addr0 = 8'h12; wdata0 = 8'h00; we0 = 1'b0;
        sb.push_back(pk(1, 0, 0, 0, 1, 0, 8'h12, 8'h00));
        sb.push_back(pk(1, 0, 1, 0, 1, 0, 8'h12, 8'h00));
        sb.push_back(pk(0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        for (int k = 0; k < 4; k++) begin
            step();
            exp_v = sb.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL single cycle %0d: got %h required %h", k, got_v, exp_v);
            end
            if (k == 1) req0 = 1'b0;
        end
    endtask

    task automatic test_contention();
        step();
        reset = 1'b0;
        #2 reset = 1'b1;
        addr0 = 8'h21; wdata0 = 8'h11; we0 = 1'b0;
        addr1 = 8'h31; wdata1 = 8'h77; we1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        sb.push_back(pk(1, 0, 0, 0, 1, 0, 8'h21, 8'h11));
        sb.push_back(pk(0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        sb.push_back(pk(0, 1, 0, 0, 1, 1, 8'h31, 8'h77));
        sb.push_back(pk(0, 1, 0, 1, 1, 0, 8'h31, 8'h77));
        sb.push_back(pk(0, 0, 0, 1, 0, 0, 8'h00, 8'h00));
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        for (int k = 0; k < 6; k++) begin
            step();
            exp_v = sb.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL contention cycle %0d: got %h required %h", k, got_v, exp_v);
            end
            case (k)
                0: req0 = 1'b0;
                2: we1 = 1'b0;
                3: req1 = 1'b0;
                default: ;
            endcase
        end
    endtask

    // Period of 10: four OWN0, TURN, four OWN1, TURN.
    task automatic test_round_robin();
        int p;
        logic o0, o1;
        addr0 = 8'h40; wdata0 = 8'h0A; we0 = 1'b0;
        addr1 = 8'h50; wdata1 = 8'h0B; we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            p  = k % 10;
            o0 = (p <= 3);
            o1 = (p >= 5) && (p <= 8);
            sb.push_back(pk(o0, o1, (p >= 1) && (p <= 4), (p >= 6),
                            o0 | o1, 1'b0,
                            o0 ? 8'h40 : (o1 ? 8'h50 : 8'h00),
                            o0 ? 8'h0A : (o1 ? 8'h0B : 8'h00)));
            step();
            exp_v = sb.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL round_robin cycle %0d: got %h required %h", k, got_v, exp_v);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        step();
        exp_v = sb.pop_front();
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL rr_release: got %h required %h", got_v, exp_v);
        end
    endtask

    // Long enough that a wrapping hold counter would read 1 when the lock drops.
    task automatic test_lock();
        addr0 = 8'h60; wdata0 = 8'h66; we0 = 1'b0;
        req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 258; k++) begin
            sb.push_back(pk(1, 0, k >= 1, 0, 1, 0, 8'h60, 8'h66));
            step();
            exp_v = sb.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL lock_hold cycle %0d: got %h required %h", k, got_v, exp_v);
            end
        end
        lock0 = 1'b0;
        sb.push_back(pk(0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        sb.push_back(pk(0, 1, 0, 0, 1, 0, 8'h50, 8'h0B));
        for (int k = 0; k < 2; k++) begin
            step();
            exp_v = sb.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL lock_release cycle %0d: got %h required %h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        req0 = 1'b0;
        we1 = 1'b1; addr1 = 8'hC3; wdata1 = 8'h5A;
        sb.push_back(pk(0, 1, 0, 0, 1, 1, 8'hC3, 8'h5A));
        step();
        exp_v = sb.pop_front();
        got_v = observe();
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL mid_owner: got %h required %h", got_v, exp_v);
        end
        #2 reset = 1'b0;
        #1;
        got_v = observe();
        n_checks++;
        if (got_v !== 22'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h required %h", got_v, 22'd0);
        end
        step();
        got_v = observe();
        n_checks++;
        if (got_v !== 22'd0) begin
            n_fail++;
            $display("FAIL mid_reset_held: got %h required %h", got_v, 22'd0);
        end
        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        we0 = 1'b0; addr0 = 8'h12; wdata0 = 8'h34; we1 = 1'b0;
        sb.push_back(pk(1, 0, 0, 0, 1, 0, 8'h12, 8'h34));
        sb.push_back(pk(0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        sb.push_back(pk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
        for (int k = 0; k < 3; k++) begin
            step();
            exp_v = sb.pop_front();
            got_v = observe();
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got %h required %h", k, got_v, exp_v);
            end
            if (k == 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_lock();
        test_reset_mid_write();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
